mem_stage: RTL and testbench

- Memory stage directly downstream of the execute stage.
- Registers the execute outputs (result, store data, PC+4, 12-bit control) into an EX/MEM register.
- Performs the data-memory load/store over a req/ready handshake, with byte-lane alignment and load extension.
- Presents a registered MEM/WB result to writeback, plus same-cycle forwarding data back to execute (its Data_MEM operand source).

---
 rtl/mem_stage.sv | 177 +++++++++++++++++
 tb/tb_mem_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, data-memory access FSM, MEM/WB register.
// Define MEM_MISALIGN_EN to trap misaligned half/word accesses.
module mem_stage #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid_i,
  input  logic [size-1:0] fu_i,
  input  logic [size-1:0] store_data_i,
  input  logic [size-1:0] pcplus_i,
  input  logic [11:0]     ctrl_i,
  output logic            stall_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [size-1:0] mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [size-1:0] mem_wdata_o,
  input  logic            mem_ready_i,
  input  logic [size-1:0] mem_rdata_i,
  output logic [size-1:0] fwd_data_o,
  output logic [4:0]      fwd_rd_o,
  output logic            fwd_we_o,
  output logic            wb_valid_o,
  output logic            wb_we_o,
  output logic [4:0]      wb_rd_o,
  output logic [size-1:0] wb_data_o,
  output logic            misalign_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state_q, state_d;

  logic            ex_valid;
  logic [size-1:0] ex_fu;
  logic [size-1:0] ex_sd;
  logic [size-1:0] ex_pc;
  logic [11:0]     ex_ctrl;

  logic [4:0]      ex_rd;
  logic            ex_rw, ex_mr, ex_mw, ex_uns, ex_wbsel;
  logic [1:0]      ex_sz;
  logic            mem_op, misal, access, req;
  logic [size-1:0] alu_val;
  logic [3:0]      lane_be;
  logic [size-1:0] st_data, ld_shift, ld_data;

  logic            wb_valid_q, wb_we_q, wb_mis_q;
  logic [4:0]      wb_rd_q;
  logic [size-1:0] wb_data_q;

  assign ex_rd    = ex_ctrl[11:7];
  assign ex_rw    = ex_ctrl[6];
  assign ex_mr    = ex_ctrl[5];
  assign ex_mw    = ex_ctrl[4];
  assign ex_sz    = ex_ctrl[3:2];
  assign ex_uns   = ex_ctrl[1];
  assign ex_wbsel = ex_ctrl[0];

  assign mem_op  = ex_valid & (ex_mr | ex_mw);
  assign alu_val = ex_wbsel ? ex_pc : ex_fu;

`ifdef MEM_MISALIGN_EN
  assign misal = mem_op &
                 (((ex_sz == 2'b01) & ex_fu[0]) |
                  (ex_sz[1] & (|ex_fu[1:0])));
`else
  assign misal = 1'b0;
`endif

  assign access = mem_op & ~misal;

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req = access;
        if (access && !mem_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        req = 1'b1;
        if (mem_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Reset kills the request in the same cycle it is asserted.
  assign mem_req_o   = req & ~reset;
  assign stall_o     = mem_req_o & ~mem_ready_i;
  assign mem_we_o    = mem_req_o & ex_mw;
  assign mem_addr_o  = {ex_fu[size-1:2], 2'b00};
  assign mem_be_o    = mem_we_o ? lane_be : 4'b0000;
  assign mem_wdata_o = st_data;

  always_comb begin
    lane_be  = 4'b1111;
    st_data  = ex_sd;
    ld_shift = mem_rdata_i;
    ld_data  = mem_rdata_i;
    unique case (1'b1)
      (ex_sz == 2'b00): begin
        lane_be  = 4'b0001 << ex_fu[1:0];
        st_data  = {4{ex_sd[7:0]}};
        ld_shift = mem_rdata_i >> {ex_fu[1:0], 3'b000};
        ld_data  = {{(size-8){ld_shift[7] & ~ex_uns}},
                    ld_shift[7:0]};
      end
      (ex_sz == 2'b01): begin
        lane_be  = 4'b0011 << {ex_fu[1], 1'b0};
        st_data  = {2{ex_sd[15:0]}};
        ld_shift = mem_rdata_i >> {ex_fu[1], 4'b0000};
        ld_data  = {{(size-16){ld_shift[15] & ~ex_uns}},
                    ld_shift[15:0]};
      end
      ex_sz[1]: begin
        lane_be  = 4'b1111;
        st_data  = ex_sd;
        ld_data  = mem_rdata_i;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_fu    <= '0;
      ex_sd    <= '0;
      ex_pc    <= '0;
      ex_ctrl  <= '0;
    end else if (!stall_o) begin
      ex_valid <= in_valid_i;
      ex_fu    <= fu_i;
      ex_sd    <= store_data_i;
      ex_pc    <= pcplus_i;
      ex_ctrl  <= ctrl_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_mis_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else if (stall_o) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_mis_q   <= 1'b0;
    end else begin
      wb_valid_q <= ex_valid;
      wb_we_q    <= ex_valid & ex_rw & ~ex_mw & ~misal;
      wb_mis_q   <= misal;
      wb_rd_q    <= ex_rd;
      wb_data_q  <= ex_mr ? ld_data : alu_val;
    end
  end

  assign fwd_data_o = alu_val;
  assign fwd_rd_o   = ex_rd;
  assign fwd_we_o   = ex_valid & ex_rw & ~ex_mr;

  assign wb_valid_o = wb_valid_q;
  assign wb_we_o    = wb_we_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign misalign_o = wb_mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed ops, queue-based model of mem/wb/fwd behaviour.
// Honours MEM_MISALIGN_EN the same way as the design.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid_i = 1'b0;
  logic [31:0] fu_i = '0, store_data_i = '0, pcplus_i = '0;
  logic [11:0] ctrl_i = '0;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, fwd_data_o, wb_data_o;
  logic [3:0]  mem_be_o;
  logic [4:0]  fwd_rd_o, wb_rd_o;
  logic        fwd_we_o, wb_valid_o, wb_we_o, misalign_o;

  mem_stage #(.size(32)) dut (
    .clk(clk), .reset(reset), .in_valid_i(in_valid_i),
    .fu_i(fu_i), .store_data_i(store_data_i),
    .pcplus_i(pcplus_i), .ctrl_i(ctrl_i),
    .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .fwd_data_o(fwd_data_o), .fwd_rd_o(fwd_rd_o),
    .fwd_we_o(fwd_we_o), .wb_valid_o(wb_valid_o),
    .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] fu, sd, pc, rdata;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [1:0]  sz;
    logic        uns, wbsel;
  } op_t;

  typedef struct {
    int          at;
    logic [4:0]  rd;
    logic        we, mis, cd;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    int          start;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        we;
  } rq_t;

  wb_t wb_q[$];
  rq_t rq_q[$];
  op_t ex_op;
  int  ex_lo = -1, ex_hi = -2;
  int  wait_k = 0, rcnt = 0;
  logic force_ready = 1'b0;
  int  passed = 0, total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h (cyc %0d)",
                  nm, act, exp, cyc);
  endtask

  function automatic op_t mk(
    input logic [31:0] fu, sd, pc, rdata, input logic [4:0] rd,
    input logic rw, mr, mw, input logic [1:0] sz,
    input logic uns, wbsel);
    op_t o;
    o.fu = fu; o.sd = sd; o.pc = pc; o.rdata = rdata; o.rd = rd;
    o.rw = rw; o.mr = mr; o.mw = mw; o.sz = sz;
    o.uns = uns; o.wbsel = wbsel;
    return o;
  endfunction

  function automatic logic mis_of(input op_t o);
`ifdef MEM_MISALIGN_EN
    if (!(o.mr || o.mw)) return 1'b0;
    if (o.sz == 2'd1) return (o.fu % 2) != 0;
    if (o.sz >= 2'd2) return (o.fu % 4) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] load_val(input op_t o);
    logic [31:0] v;
    if (o.sz == 2'd0) begin
      v = (o.rdata >> (8 * (o.fu % 4))) & 32'hFF;
      if (!o.uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (o.sz == 2'd1) begin
      v = (o.rdata >> (16 * ((o.fu / 2) % 2))) & 32'hFFFF;
      if (!o.uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else v = o.rdata;
    return v;
  endfunction

  function automatic logic [31:0] wdata_of(input op_t o);
    if (o.sz == 2'd0) return (o.sd & 32'hFF) * 32'h0101_0101;
    if (o.sz == 2'd1) return (o.sd & 32'hFFFF) * 32'h0001_0001;
    return o.sd;
  endfunction

  function automatic logic [3:0] be_of(input op_t o);
    if (o.sz == 2'd0) return 4'd1 << (o.fu % 4);
    if (o.sz == 2'd1) return 4'd3 << (2 * ((o.fu / 2) % 2));
    return 4'hF;
  endfunction

  // Call at a negedge; returns at the following negedge.
  task automatic issue(input op_t o, input int k);
    int n;
    logic m;
    rq_t r;
    wb_t w;
    m = mis_of(o);
    n = cyc;
    if (!(o.mr || o.mw) || m) k = 0;
    in_valid_i = 1'b1; fu_i = o.fu; store_data_i = o.sd;
    pcplus_i = o.pc;
    ctrl_i = {o.rd, o.rw, o.mr, o.mw, o.sz, o.uns, o.wbsel};
    wait_k = k; mem_rdata_i = o.rdata;
    ex_op = o; ex_lo = n + 1; ex_hi = n + 1 + k;
    if ((o.mr || o.mw) && !m) begin
      r.start = n + 1; r.addr = o.fu & 32'hFFFF_FFFC;
      r.wdata = wdata_of(o); r.be = be_of(o); r.we = o.mw;
      rq_q.push_back(r);
    end
    w.at = n + 2 + k; w.rd = o.rd; w.mis = m;
    w.we = o.rw && !o.mw && !m;
    w.cd = !(m && o.mr);
    w.data = o.mr ? load_val(o) : (o.wbsel ? o.pc : o.fu);
    wb_q.push_back(w);
    @(posedge clk);
    @(negedge clk);
    in_valid_i = 1'b0; fu_i = '0; store_data_i = '0;
    pcplus_i = '0; ctrl_i = '0;
  endtask

  task automatic to_wb(input int k);
    repeat (k + 1) @(negedge clk);
    #3;
  endtask

  task automatic run(input op_t o, input int k);
    issue(o, k);
    to_wb(mis_of(o) || !(o.mr || o.mw) ? 0 : k);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      rcnt = 0; mem_ready_i = 1'b0;
    end else if (force_ready) mem_ready_i = 1'b1;
    else if (mem_req_o) begin
      if (rcnt >= wait_k) begin mem_ready_i = 1'b1; rcnt = 0; end
      else begin mem_ready_i = 1'b0; rcnt++; end
    end else begin
      mem_ready_i = 1'b0; rcnt = 0;
    end
  end

  wb_t  e;
  logic act, fe;
  always begin
    @(negedge clk);
    #3;
    if (cyc > 0) begin
      if (wb_valid_o === 1'b1) begin
        if (wb_q.size() == 0) chk("wb_spurious", 32'(wb_valid_o), 32'd0);
        else begin
          e = wb_q.pop_front();
          chk("wb_cycle", 32'(cyc), 32'(e.at));
          chk("wb_we", 32'(wb_we_o), 32'(e.we));
          chk("wb_rd", 32'(wb_rd_o), 32'(e.rd));
          if (e.cd) chk("wb_data", wb_data_o, e.data);
          chk("misalign", 32'(misalign_o), 32'(e.mis));
        end
      end else begin
        act = wb_q.size() > 0 && wb_q[0].at <= cyc;
        chk("wb_valid", 32'(wb_valid_o), 32'(act));
        if (act) void'(wb_q.pop_front());
        chk("wb_we_idle", 32'(wb_we_o), 32'd0);
        chk("misalign_idle", 32'(misalign_o), 32'd0);
      end
      act = rq_q.size() > 0 && rq_q[0].start <= cyc;
      chk("mem_req", 32'(mem_req_o), 32'(act));
      chk("stall", 32'(stall_o), 32'(act && !mem_ready_i));
      if (act && mem_req_o) begin
        chk("mem_addr", mem_addr_o, rq_q[0].addr);
        chk("mem_we", 32'(mem_we_o), 32'(rq_q[0].we));
        if (rq_q[0].we) begin
          chk("mem_be", 32'(mem_be_o), 32'(rq_q[0].be));
          chk("mem_wdata", mem_wdata_o, rq_q[0].wdata);
        end
        if (mem_ready_i) void'(rq_q.pop_front());
      end
      fe = cyc >= ex_lo && cyc <= ex_hi && ex_op.rw && !ex_op.mr;
      chk("fwd_we", 32'(fwd_we_o), 32'(fe));
      if (fe) begin
        chk("fwd_rd", 32'(fwd_rd_o), 32'(ex_op.rd));
        chk("fwd_data", fwd_data_o,
            ex_op.wbsel ? ex_op.pc : ex_op.fu);
      end
    end
  end

  int ns, nr;
  initial begin
    @(negedge clk); #3;
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(mk(32'h1234, 0, 32'h8, 0, 5'd5, 1, 0, 0, 2'd0, 0, 0), 0);
    #3;
    chk("lit_fwd_data", fwd_data_o, 32'h0000_1234);
    chk("lit_fwd_rd", 32'(fwd_rd_o), 32'd5);
    to_wb(0);
    chk("lit_alu_valid", 32'(wb_valid_o), 32'd1);
    chk("lit_alu_rd", 32'(wb_rd_o), 32'd5);
    chk("lit_alu_data", wb_data_o, 32'h0000_1234);
    @(negedge clk);

    issue(mk(32'h103, 0, 0, 32'h80FF_0000, 5'd6, 1, 1, 0, 2'd0, 0, 0), 0);
    #3;
    chk("lit_lb_addr", mem_addr_o, 32'h100);
    chk("lit_lb_stall", 32'(stall_o), 32'd0);
    to_wb(0);
    chk("lit_lb_data", wb_data_o, 32'hFFFF_FF80);
    @(negedge clk);
    issue(mk(32'h103, 0, 0, 32'h80FF_0000, 5'd6, 1, 1, 0, 2'd0, 1, 0), 0);
    to_wb(0);
    chk("lit_lbu_data", wb_data_o, 32'h0000_0080);
    @(negedge clk);

    issue(mk(32'h202, 32'hABCD, 0, 0, 5'd7, 1, 0, 1, 2'd1, 0, 0), 3);
    #3;
    ns = 0; nr = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #3; end
      ns += int'(stall_o); nr += int'(mem_req_o);
      chk("lit_sh_addr", mem_addr_o, 32'h200);
      chk("lit_sh_be", 32'(mem_be_o), 32'hC);
      chk("lit_sh_wdata", mem_wdata_o, 32'hABCD_ABCD);
    end
    chk("lit_sh_stalls", 32'(ns), 32'd3);
    chk("lit_sh_reqs", 32'(nr), 32'd4);
    @(negedge clk); #3;
    chk("lit_sh_wb_valid", 32'(wb_valid_o), 32'd1);
    chk("lit_sh_wb_we", 32'(wb_we_o), 32'd0);
    @(negedge clk);

    run(mk(32'h102, 0, 0, 32'h8765_4321, 5'd8, 1, 1, 0, 2'd1, 1, 0), 1);
    run(mk(32'h102, 0, 0, 32'h8765_4321, 5'd8, 1, 1, 0, 2'd1, 0, 0), 0);
    run(mk(32'h300, 0, 0, 32'hDEAD_BEEF, 5'd9, 1, 1, 0, 2'd2, 0, 0), 2);
    run(mk(32'h001, 32'h5A, 0, 0, 5'd0, 0, 0, 1, 2'd0, 0, 0), 0);
    run(mk(32'h008, 32'h1234_5678, 0, 0, 5'd0, 0, 0, 1, 2'd3, 0, 0), 1);
    run(mk(32'h103, 0, 0, 32'hCAFE_0001, 5'd10, 1, 1, 0, 2'd1, 0, 0), 0);
    run(mk(32'h0, 0, 32'h44, 0, 5'd1, 1, 0, 0, 2'd0, 0, 1), 0);
    #3;
    chk("lit_bubble_wb_valid", 32'(wb_valid_o), 32'd0);
    @(negedge clk);

    issue(mk(32'h301, 0, 0, 32'h1122_3344, 5'd11, 1, 1, 0, 2'd2, 0, 0), 0);
    #3;
`ifdef MEM_MISALIGN_EN
    chk("lit_mis_req", 32'(mem_req_o), 32'd0);
    to_wb(0);
    chk("lit_mis_flag", 32'(misalign_o), 32'd1);
    chk("lit_mis_we", 32'(wb_we_o), 32'd0);
    @(negedge clk); #3;
    chk("lit_mis_flag_drop", 32'(misalign_o), 32'd0);
`else
    chk("lit_mis_addr", mem_addr_o, 32'h300);
    to_wb(0);
    chk("lit_mis_data", wb_data_o, 32'h1122_3344);
    @(negedge clk); #3;
`endif
    @(negedge clk);

    issue(mk(32'h400, 32'h77, 0, 0, 5'd12, 0, 0, 1, 2'd2, 0, 0), 10);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wb_q.delete(); rq_q.delete(); ex_hi = -2;
    #3;
    chk("lit_rst_req_now", 32'(mem_req_o), 32'd0);
    @(negedge clk); #3;
    chk("lit_rst_req", 32'(mem_req_o), 32'd0);
    chk("lit_rst_stall", 32'(stall_o), 32'd0);
    chk("lit_rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("lit_rst_addr", mem_addr_o, 32'd0);
    chk("lit_rst_be", 32'(mem_be_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    force_ready = 1'b1;
    @(negedge clk);
    force_ready = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("lit_rst_no_wb", 32'(wb_valid_o), 32'd0);
    chk("lit_rst_no_we", 32'(wb_we_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
